// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment display driver.
// Captures a 32-bit hex word and an 8-bit decimal-point mask on `load` into a
// shadow register. It then scans one digit per SCAN_DIV cycles onto the shared
// active-low digit/segment pins. All pins are registered.
//
// Optional feature: define SEG_LZ_BLANK_EN to blank leading zero digits.
// Digit 0 is never blanked. A blanked digit whose dot bit is set shows the dp only.
//
// Handshake: none. `load` is a level-sampled strobe with no back-pressure.
// While `load` is high, the inputs are recaptured on every edge. `rst` overrides `load`.
module seg_scan_driver #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        CCLK,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dot_en,
  output logic [7:0]  digit,
  output logic [7:0]  segment,
  output logic        scan_tick
);

  logic [15:0] pcnt_q,    pcnt_d;
  logic [2:0]  idx_q,     idx_d;
  logic [31:0] shadow_q,  shadow_d;
  logic [7:0]  dots_q,    dots_d;
  logic [7:0]  digit_q,   digit_d;
  logic [7:0]  segment_q, segment_d;
  logic        tick_q,    tick_d;

  logic        tc;
  logic [3:0]  nibble;
  logic        dot_bit;
  logic [31:0] upper;

  // Active-low glyph for one hex nibble, with the dp bit (7) off.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Select the nibble and dot for the digit index. The word is shifted down so
  // that nibble idx lands in bits [3:0], and nibbles idx..7 form `upper`.
  always_comb begin
    upper   = shadow_q >> {idx_q, 2'b00};
    nibble  = upper[3:0];
    dot_bit = dots_q[idx_q];
    tc      = (pcnt_q == SCAN_DIV - 16'd1);
  end

  // Next-state logic for the prescaler, ring index, shadow and output pins.
  always_comb begin
    pcnt_d    = pcnt_q + 16'd1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    dots_d    = dots_q;
    digit_d   = digit_q;
    segment_d = segment_q;
    tick_d    = 1'b0;

    if (load) begin
      shadow_d = data;
      dots_d   = dot_en;
    end

    // The decode reads shadow_q, so a load on a TC edge only shows at a later TC.
    if (tc) begin
      pcnt_d    = 16'd0;
      idx_d     = idx_q + 3'd1;
      tick_d    = 1'b1;
      digit_d   = ~(8'b1 << idx_q);
      segment_d = {~dot_bit, hex7(nibble)[6:0]};
`ifdef SEG_LZ_BLANK_EN
      if ((idx_q != 3'd0) && (upper == 32'd0)) begin
        if (dot_bit) begin
          segment_d = 8'h7F;
        end else begin
          segment_d = 8'hFF;
          digit_d   = 8'hFF;
        end
      end
`endif
    end
  end

  // State register. Reset darkens the display, clears the shadow and restarts the scan.
  always_ff @(posedge CCLK) begin
    if (rst) begin
      pcnt_q    <= 16'd0;
      idx_q     <= 3'd0;
      shadow_q  <= 32'd0;
      dots_q    <= 8'd0;
      digit_q   <= 8'hFF;
      segment_q <= 8'hFF;
      tick_q    <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      dots_q    <= dots_d;
      digit_q   <= digit_d;
      segment_q <= segment_d;
      tick_q    <= tick_d;
    end
  end

  assign digit     = digit_q;
  assign segment   = segment_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with SCAN_DIV = 4.
// The stimulus process drives load/rst and pushes the expected {digit, segment}
// for each upcoming scan slot into exp_q. The monitor pops one entry on every
// scan_tick and compares it. The monitor also checks that scan ticks are 4 cycles apart.
module tb_seg_scan_driver;

  localparam logic [15:0] DIV = 16'd4;

  logic        CCLK;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic [7:0]  dot_en;
  logic [7:0]  digit;
  logic [7:0]  segment;
  logic        scan_tick;

  logic [15:0] exp_q[$];
  int checks;
  int errors;
  int cyc;
  int slot;

  seg_scan_driver #(.SCAN_DIV(DIV)) dut (
    .CCLK      (CCLK),
    .rst       (rst),
    .load      (load),
    .data      (data),
    .dot_en    (dot_en),
    .digit     (digit),
    .segment   (segment),
    .scan_tick (scan_tick)
  );

  // Clock and cycle counter.
  initial begin
    CCLK = 1'b0;
    forever #5 CCLK = ~CCLK;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge CCLK);
      cyc = cyc + 1;
    end
  end

  // Driver helpers.
  task automatic step(input int n);
    repeat (n) @(posedge CCLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] s);
    exp_q.push_back({d, s});
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the active edge.
  initial begin
    logic [15:0] e;
    int prev_cyc;
    bit have_prev;
    have_prev = 1'b0;
    prev_cyc  = 0;
    slot      = 0;
    forever begin
      @(negedge CCLK);
      if (rst === 1'b1) have_prev = 1'b0;
      if (scan_tick === 1'b1) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL slot%0d: unexpected tick digit=%h segment=%h", slot, digit, segment);
        end else begin
          e = exp_q.pop_front();
          if ({digit, segment} !== e) begin
            errors = errors + 1;
            $display("FAIL slot%0d: digit/segment got %h/%h expected %h/%h",
                     slot, digit, segment, e[15:8], e[7:0]);
          end
        end
        if (have_prev) begin
          checks = checks + 1;
          if (cyc - prev_cyc != 4) begin
            errors = errors + 1;
            $display("FAIL tick_period slot%0d: got %0d expected 4", slot, cyc - prev_cyc);
          end
        end
        prev_cyc  = cyc;
        have_prev = 1'b1;
        slot      = slot + 1;
      end
    end
  end

  // Directed stimulus.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    load   = 1'b1;          // This load must be ignored while in reset.
    data   = 32'h88888888;
    dot_en = 8'hFF;
    step(2);
    check8("reset_digit", digit, 8'hFF);
    check8("reset_segment", segment, 8'hFF);
    check8("reset_tick", {7'd0, scan_tick}, 8'h00);
    rst  = 1'b0;
    load = 1'b0;

    // Phase A: the first slot shows the cleared shadow. After that, 76543210 scans.
    push(8'hFE, 8'hC0);
    push(8'hFD, 8'hF9); push(8'hFB, 8'hA4); push(8'hF7, 8'hB0); push(8'hEF, 8'h99);
    push(8'hDF, 8'h92); push(8'hBF, 8'h82); push(8'h7F, 8'hF8); push(8'hFE, 8'hC0);
    step(3);
    check8("pre_first_tc_digit", digit, 8'hFF);
    step(1);
    data = 32'h76543210; dot_en = 8'h00; load = 1'b1;
    step(1);
    load = 1'b0;

    // Phase B: FEDCBA98 with dp on digit 0.
    push(8'hFD, 8'h90); push(8'hFB, 8'h88); push(8'hF7, 8'h83); push(8'hEF, 8'hC6);
    push(8'hDF, 8'hA1); push(8'hBF, 8'h86); push(8'h7F, 8'h8E); push(8'hFE, 8'h00);
    step(31);
    data = 32'hFEDCBA98; dot_en = 8'h01; load = 1'b1;
    step(1);
    load = 1'b0;

    // Phase C: the load lands on the TC edge for digit 3. That slot still shows the old B.
    push(8'hFD, 8'h90); push(8'hFB, 8'h88); push(8'hF7, 8'h83); push(8'hEF, 8'hB0);
    push(8'hDF, 8'hA4); push(8'hBF, 8'hF9); push(8'h7F, 8'h80); push(8'hFE, 8'hF8);
    push(8'hFD, 8'h82); push(8'hFB, 8'h92); push(8'hF7, 8'h99); push(8'hEF, 8'hB0);
    push(8'hDF, 8'hA4);
    step(42);
    data = 32'h81234567; dot_en = 8'h00; load = 1'b1;
    step(1);
    load = 1'b0;

    // Phase D: reset while digit 5 is lit. Digit 0 returns 4 cycles later with a cleared shadow.
    push(8'hFE, 8'hC0);
    step(41);
    check8("digit5_lit", digit, 8'hDF);
    rst = 1'b1;
    step(1);
    check8("midscan_reset_digit", digit, 8'hFF);
    check8("midscan_reset_segment", segment, 8'hFF);
    rst = 1'b0;
    step(3);
    check8("restart_wait_digit", digit, 8'hFF);
    check8("restart_wait_tick", {7'd0, scan_tick}, 8'h00);
    step(1);
    check8("restart_tick", {7'd0, scan_tick}, 8'h01);
    check8("restart_digit", digit, 8'hFE);

    // Phase E: 00000305, which has leading zeros, then dp on digit 7.
    push(8'hFD, 8'hC0); push(8'hFB, 8'hB0);
`ifdef SEG_LZ_BLANK_EN
    push(8'hFF, 8'hFF); push(8'hFF, 8'hFF); push(8'hFF, 8'hFF);
    push(8'hFF, 8'hFF); push(8'hFF, 8'hFF);
`else
    push(8'hF7, 8'hC0); push(8'hEF, 8'hC0); push(8'hDF, 8'hC0);
    push(8'hBF, 8'hC0); push(8'h7F, 8'hC0);
`endif
    push(8'hFE, 8'h92);
    push(8'hFD, 8'hC0); push(8'hFB, 8'hB0);
`ifdef SEG_LZ_BLANK_EN
    push(8'hFF, 8'hFF); push(8'hFF, 8'hFF); push(8'hFF, 8'hFF); push(8'hFF, 8'hFF);
    push(8'h7F, 8'h7F);
`else
    push(8'hF7, 8'hC0); push(8'hEF, 8'hC0); push(8'hDF, 8'hC0); push(8'hBF, 8'hC0);
    push(8'h7F, 8'h40);
`endif
    data = 32'h00000305; dot_en = 8'h00; load = 1'b1;
    step(1);
    load = 1'b0;
    step(31);
    dot_en = 8'h80; load = 1'b1;
    step(1);
    load = 1'b0;
    step(28);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL pending_slots: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
